rv32i_fetch_unit: RTL and testbench
===================================

# rv32i_fetch_unit

Instruction fetch stage for the RV32I single-cycle core. It generates sequential PCs, issues requests to the instruction memory over a valid/ready port, and buffers in-order responses in a small prefetch FIFO. Each buffered word is presented to the downstream decode/execute stage with its PC over a valid/ready handshake. Branch and jump redirects from execute flush the buffer, discard in-flight responses, and restart fetch at the new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, prefetch FIFO entries; power of two, ≥2; also bounds outstanding requests.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse: restart fetch.
- redirect_pc  in  32  new PC.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  consumer takes the head.
- inst_data  out  32  instruction word.
- inst_pc  out  32  PC of inst_data.
- inst_fault  out  1  misaligned-target marker; tied 0 without the macro.

## Operation
- State: fetch_pc, outstanding count (0..DEPTH), discard count (0..DEPTH), FIFO entries of {fault, pc, data}.
- Credit rule: imem_req_valid = !halted && (outstanding + fifo_count < DEPTH). imem_req_addr = fetch_pc.
- Request handshake (valid && ready): outstanding +1; fetch_pc += 4, with 32-bit wrap (32'hFFFF_FFFC → 0).
- Response: outstanding −1. If discard > 0, discard −1 and drop the word. Otherwise push {0, pc, data}. The pc is tracked by a separate rsp_pc register that advances +4 per kept response.
- Pop when inst_valid && inst_ready. Push and pop in the same cycle are legal at full or empty.
- Redirect (highest priority):
  - FIFO flushed; fetch_pc = rsp_pc = redirect_pc.
  - discard = outstanding + (request handshake this cycle) − (rsp_valid this cycle).
  - A response arriving in the redirect cycle is dropped. A pop in the same cycle is honoured for the consumer but the entry is flushed anyway.
- Credit rule guarantees no FIFO overflow; an overflow is an assertion failure.
- Reset mid-operation: all counts 0, FIFO empty, fetch_pc = rsp_pc = RESET_PC. Late responses from before reset are the memory's responsibility; rst is applied to both sides.

## Timing
- Reset values: imem_req_valid 0 while rst is high, imem_req_addr RESET_PC, inst_valid 0, inst_data 0, inst_pc 0, inst_fault 0.
- First cycle after rst deasserts: imem_req_valid=1, addr=RESET_PC.
- Response in cycle N → inst_valid in cycle N+1 (registered FIFO; no bypass).
- Redirect in cycle 0 → request for redirect_pc in cycle 1 → earliest response cycle 2 → inst_valid cycle 3.
- Steady state with 1-cycle memory and DEPTH=2: one instruction per cycle while inst_ready=1.
- imem_req_valid may drop without handshake only on redirect or credit loss; the address is stable while valid is high otherwise.

## Configuration
- RV_FETCH_MISALIGN_EN defined:
  - A redirect with redirect_pc[1:0]≠0 issues no request.
  - Pushes one entry {fault=1, pc=redirect_pc, data=32'h0000_0013}.
  - Sets halted, clearing imem_req_valid until the next aligned redirect or reset.
  - Discard rules are unchanged.
- Undefined: redirect_pc[1:0] is forced to 0; inst_fault is constant 0; no halted state.

## Structure
- Shared package rv32i_pkg holds:
  - the RESET_PC default constant;
  - NOP_INSN = 32'h0000_0013;
  - a fetch_entry_t struct {fault, pc, data}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, parameterised by DEPTH, with flush, push, pop, count and full/empty outputs.
- Top level holds the PC, outstanding/discard counters and credit logic.

## Test plan
- Reset, 1-cycle memory returning addr-tagged words, inst_ready=1: inst_pc sequence 0,4,8,… one per cycle from cycle 3; no gaps.
- inst_ready=0 for 10 cycles: exactly DEPTH requests issued, imem_req_valid=0 afterwards; release → entries drain in order, fetch resumes.
- 3-cycle memory latency: redirect to 0x100 while 2 requests are outstanding → both old responses dropped; first inst_pc=0x100.
- Redirect coincident with a response and a request handshake: discard count correct; no stale word appears after the redirect.
- fetch_pc 0xFFFF_FFF8 → emits 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With RV_FETCH_MISALIGN_EN, redirect to 0x102 → single entry {fault=1, pc=0x102, data=0x13}, no requests; redirect to 0x200 resumes fetch.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants and the fetch buffer entry type for the RV32I core
package rv32i_pkg;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    typedef struct packed {
        logic fault;
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;
endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// rv32i_fetch_unit_if: instruction memory, redirect and decode-side handshakes of the fetch stage
interface rv32i_fetch_unit_if;
    logic imem_req_valid;
    logic imem_req_ready;
    logic [31:0] imem_req_addr;
    logic imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic redirect_valid;
    logic [31:0] redirect_pc;
    logic inst_valid;
    logic inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic inst_fault;
    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_fault,
        input imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/rv32i_fetch_unit_fetch_fifo.sv
// fetch_fifo: registered prefetch queue of fetch entries with flush
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    input logic flush,
    input logic push,
    input logic pop,
    input fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [CW-1:0] count,
    output logic full,
    output logic empty
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd, wr, wa;

    assign wa = flush ? '0 : wr;
    assign dout = mem[rd];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;

    // Entry storage; a push during flush lands in slot 0 as the sole survivor
    always_ff @(posedge clk)
        if (push) mem[wa] <= din;

    // Pointers and occupancy; flush drops everything except a same-cycle push
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (flush) begin
            rd <= '0;
            wr <= push ? AW'(1) : '0;
            count <= push ? CW'(1) : '0;
        end else begin
            if (push) wr <= wr + AW'(1);
            if (pop) rd <= rd + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: PC sequencing, credit-limited imem requests and redirect discard; RV_FETCH_MISALIGN_EN enables misaligned-redirect faults
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    rv32i_fetch_unit_if.master bus
);
    logic [31:0] fetch_pc, rsp_pc, target;
    logic [CW-1:0] outstanding, discard, out_next, fifo_count;
    logic [CW:0] used;
    logic req_fire, pop, keep, push, misaligned, halted, full, empty;
    fetch_entry_t push_entry, head;

`ifdef RV_FETCH_MISALIGN_EN
    assign target = bus.redirect_pc;
    assign misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    // A misaligned redirect parks fetch until an aligned redirect or reset
    always_ff @(posedge clk or posedge rst)
        if (rst) halted <= 1'b0;
        else if (bus.redirect_valid) halted <= misaligned;
`else
    assign target = bus.redirect_pc & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
    assign halted = 1'b0;
`endif

    // A head leaving this cycle frees its slot for the request issued now
    assign pop = bus.inst_valid && bus.inst_ready;
    assign used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    assign bus.imem_req_valid = !rst && !halted && (used < (CW + 1)'(DEPTH));
    assign bus.imem_req_addr = fetch_pc;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign out_next = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    assign keep = bus.imem_rsp_valid && discard == '0 && !bus.redirect_valid;
    assign push = keep || misaligned;
    assign push_entry = misaligned ? '{fault: 1'b1, pc: bus.redirect_pc, data: NOP_INSN}
                                   : '{fault: 1'b0, pc: rsp_pc, data: bus.imem_rsp_data};

    assign bus.inst_valid = !empty;
    assign bus.inst_data = empty ? '0 : head.data;
    assign bus.inst_pc = empty ? '0 : head.pc;
    assign bus.inst_fault = !empty && head.fault;

    fetch_fifo #(.DEPTH(DEPTH)) fifo (
        .clk(clk),
        .rst(rst),
        .flush(bus.redirect_valid),
        .push(push),
        .pop(pop),
        .din(push_entry),
        .dout(head),
        .count(fifo_count),
        .full(full),
        .empty(empty)
    );

    // PCs and in-flight bookkeeping; a redirect turns every response still owed into a discard
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outstanding <= '0;
            discard <= '0;
        end else begin
            outstanding <= out_next;
            if (bus.redirect_valid) begin
                fetch_pc <= target;
                rsp_pc <= target;
                discard <= out_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (keep) rsp_pc <= rsp_pc + 32'd4;
                if (bus.imem_rsp_valid && discard != '0) discard <= discard - CW'(1);
            end
        end

    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !bus.redirect_valid));
endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: directed vector table plus redirect, wrap, reset and misalign sequences
module tb_rv32i_fetch_unit;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv32i_fetch_unit_if bus();
    rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic ready;
        logic redir;
        logic [31:0] rpc;
        logic exp_rv;
        logic [31:0] exp_addr;
        logic exp_iv;
        logic [31:0] exp_pc;
    } vec_t;
    typedef struct { int due; logic [31:0] addr; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; logic fault; } got_t;

    vec_t tv[$];
    req_t mq[$];
    got_t got[$];
    int checks = 0, errors = 0, cycle = 0, lat = 1, nreq = 0;
    logic o_rv, o_iv;
    logic [31:0] o_addr, o_pc, o_data;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic void add(input logic r, input logic d, input logic [31:0] rpc,
                                input logic rv, input logic [31:0] a, input logic iv, input logic [31:0] pc);
        tv.push_back('{r, d, rpc, rv, a, iv, pc});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_got(input string name, input int i, input logic [31:0] pc,
                           input logic [31:0] data, input logic fault);
        if (got.size() <= i) begin
            checks++;
            errors++;
            $display("FAIL %s: entry %0d missing (%0d taken), want pc %h", name, i, got.size(), pc);
        end else begin
            chk({name, " pc"}, got[i].pc, pc);
            chk({name, " data"}, got[i].data, data);
            chk({name, " fault"}, {31'b0, got[i].fault}, {31'b0, fault});
        end
    endtask

    // One clock: sample at negedge, run the memory model, drive next-cycle response after posedge
    task automatic cyc();
        @(negedge clk);
        o_rv = bus.imem_req_valid;
        o_addr = bus.imem_req_addr;
        o_iv = bus.inst_valid;
        o_pc = bus.inst_pc;
        o_data = bus.inst_data;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            mq.push_back('{cycle + lat, bus.imem_req_addr});
            nreq++;
        end
        if (bus.inst_valid && bus.inst_ready) got.push_back('{bus.inst_pc, bus.inst_data, bus.inst_fault});
        @(posedge clk);
        #1;
        cycle++;
        bus.redirect_valid = 1'b0;
        if (mq.size() > 0 && mq[0].due == cycle) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = tag(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data = '0;
        end
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        #1;
        chk("async reset inst_valid", {31'b0, bus.inst_valid}, 0);
        mq.delete();
        got.delete();
        lat = l;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;
        @(negedge clk);
        chk("reset req_valid", {31'b0, bus.imem_req_valid}, 0);
        chk("reset req_addr", bus.imem_req_addr, 32'h0);
        chk("reset inst_valid", {31'b0, bus.inst_valid}, 0);
        chk("reset inst_data", bus.inst_data, 0);
        chk("reset inst_pc", bus.inst_pc, 0);
        chk("reset inst_fault", {31'b0, bus.inst_fault}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle = 1;
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b0;

        // cycles 1..10 stalled, release, then a redirect coincident with response and handshake
        add(0, 0, 0, 1, 32'h00, 0, 0);
        add(0, 0, 0, 1, 32'h04, 0, 0);
        for (int i = 3; i <= 10; i++) add(0, 0, 0, 0, 0, 1, 32'h00);
        add(1, 0, 0, 1, 32'h08, 1, 32'h00);
        add(1, 0, 0, 1, 32'h0C, 1, 32'h04);
        add(1, 0, 0, 1, 32'h10, 1, 32'h08);
        add(1, 0, 0, 1, 32'h14, 1, 32'h0C);
        add(1, 0, 0, 1, 32'h18, 1, 32'h10);
        add(1, 1, 32'h40, 1, 32'h1C, 1, 32'h14);
        add(1, 0, 0, 1, 32'h40, 0, 0);
        add(1, 0, 0, 1, 32'h44, 0, 0);
        add(1, 0, 0, 1, 32'h48, 1, 32'h40);
        add(1, 0, 0, 1, 32'h4C, 1, 32'h44);

        do_reset(1);
        foreach (tv[i]) begin
            bus.inst_ready = tv[i].ready;
            bus.redirect_valid = tv[i].redir;
            bus.redirect_pc = tv[i].rpc;
            cyc();
            chk($sformatf("vec%0d req_valid", i + 1), {31'b0, o_rv}, {31'b0, tv[i].exp_rv});
            if (tv[i].exp_rv) chk($sformatf("vec%0d req_addr", i + 1), o_addr, tv[i].exp_addr);
            chk($sformatf("vec%0d inst_valid", i + 1), {31'b0, o_iv}, {31'b0, tv[i].exp_iv});
            if (tv[i].exp_iv) begin
                chk($sformatf("vec%0d inst_pc", i + 1), o_pc, tv[i].exp_pc);
                chk($sformatf("vec%0d inst_data", i + 1), o_data, tag(tv[i].exp_pc));
            end
        end

        do_reset(3);
        bus.inst_ready = 1'b1;
        cyc();
        chk("lat3 c1 req_valid", {31'b0, o_rv}, 1);
        chk("lat3 c1 req_addr", o_addr, 32'h0);
        cyc();
        chk("lat3 c2 req_addr", o_addr, 32'h4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        cyc();
        chk("lat3 redirect credit", {31'b0, o_rv}, 0);
        got.delete();
        cyc();
        chk("lat3 post-redirect credit", {31'b0, o_rv}, 0);
        cyc();
        chk("lat3 restart req_valid", {31'b0, o_rv}, 1);
        chk("lat3 restart req_addr", o_addr, 32'h100);
        repeat (8) cyc();
        chk_got("lat3 first", 0, 32'h100, tag(32'h100), 1'b0);
        chk_got("lat3 second", 1, 32'h104, tag(32'h104), 1'b0);

        do_reset(1);
        bus.inst_ready = 1'b1;
        cyc();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        cyc();
        got.delete();
        repeat (8) cyc();
        chk_got("wrap 0", 0, 32'hFFFF_FFF8, tag(32'hFFFF_FFF8), 1'b0);
        chk_got("wrap 1", 1, 32'hFFFF_FFFC, tag(32'hFFFF_FFFC), 1'b0);
        chk_got("wrap 2", 2, 32'h0000_0000, tag(32'h0000_0000), 1'b0);

`ifdef RV_FETCH_MISALIGN_EN
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h102;
        cyc();
        got.delete();
        nreq = 0;
        cyc();
        chk("misalign inst_valid", {31'b0, o_iv}, 1);
        chk("misalign inst_pc", o_pc, 32'h102);
        chk("misalign inst_data", o_data, NOP_INSN);
        chk("misalign inst_fault", {31'b0, bus.inst_fault}, 1);
        chk("misalign req_valid", {31'b0, o_rv}, 0);
        repeat (4) cyc();
        chk("misalign requests", nreq, 0);
        bus.inst_ready = 1'b1;
        repeat (4) cyc();
        chk("misalign entry count", got.size(), 1);
        chk_got("misalign entry", 0, 32'h102, NOP_INSN, 1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h200;
        cyc();
        got.delete();
        repeat (6) cyc();
        chk_got("resume after fault", 0, 32'h200, tag(32'h200), 1'b0);
`else
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h102;
        cyc();
        got.delete();
        repeat (6) cyc();
        chk_got("forced align", 0, 32'h100, tag(32'h100), 1'b0);
        chk_got("forced align next", 1, 32'h104, tag(32'h104), 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
